logic_unit_seq: RTL and testbench
=================================

// Module: logic_unit_seq
// PURPOSE
//  Sequential, handshaked successor to the combinational ALU logic unit.
//  - Keeps the bitwise ops: AND, OR, XOR, ~opd1, ~opd2.
//  - Adds iterative bit-scan ops: population count and count-leading-zeros.
//  - Sits between the ALU operand stage and writeback, with valid/ready on both sides.
// PARAMETERS
//  OPD_LENGTH      8  operand and result width in bits (>= 2)
//  BITS_PER_CYCLE  1  bits scanned per cycle in iterative ops; must divide OPD_LENGTH
// PORTS
//  clk            in   1           rising-edge clock
//  rst_n          in   1           asynchronous active-low reset
//  in_valid       in   1           operation request valid
//  in_ready       out  1           unit can accept a request this cycle
//  opd1           in   OPD_LENGTH  operand 1
//  opd2           in   OPD_LENGTH  operand 2
//  alu_op_select  in   4           operation code (table below)
//  out_valid      out  1           logic_result/illegal_op valid
//  out_ready      in   1           consumer accepts result this cycle
//  logic_result   out  OPD_LENGTH  registered result
//  illegal_op     out  1           registered; 1 = unsupported opcode
// BEHAVIOUR
//  Opcodes
//  - Single-cycle: 0111 AND, 0110 OR, 0100 XOR, 0000 ~opd1, 0001 ~opd2.
//  - Iterative:    1000 POPCNT(opd1), 1001 CLZ(opd1).
//  - Any other code is illegal.
//  Reset (async, rst_n=0)
//  - state=IDLE; logic_result=0; illegal_op=0; out_valid=0; scan counter=0.
//  - A reset mid-operation aborts it; no result is produced.
//  FSM states: IDLE, ITER, HOLD. in_ready = (state==IDLE) | (state==HOLD & out_ready).
//  Accept (in_valid & in_ready)
//  - Latch opd1, opd2 and the opcode.
//  - Single-cycle op: logic_result and illegal_op update at the same edge; next state HOLD.
//  - Illegal op: logic_result=0, illegal_op=1; next state HOLD. Latency 1 cycle.
//  - Iterative op: clear counter/accumulator; next state ITER.
//  ITER
//  - Each cycle scans BITS_PER_CYCLE bits of latched opd1.
//  - POPCNT scans LSB-first.
//  - CLZ scans MSB-first and stops incrementing after the first 1 is seen.
//  - Runs exactly N = OPD_LENGTH/BITS_PER_CYCLE cycles, independent of the data.
//  - On the N-th cycle, write the count (zero-extended) to logic_result, set illegal_op=0, go to HOLD.
//  - Latency from accept edge to out_valid is N+1 cycles. in_ready=0 throughout ITER.
//  - CLZ(0) = OPD_LENGTH. POPCNT(all ones) = OPD_LENGTH.
//  HOLD
//  - out_valid=1; logic_result and illegal_op stay stable until out_ready=1.
//  - On out_ready with in_valid=0: go to IDLE, out_valid falls next cycle.
//  - On out_ready with in_valid=1 in the same cycle: retire the old result and accept the new
//    request at that same edge. Back-to-back throughput is 1 result per cycle for single-cycle ops.
//  out_valid = (state==HOLD). Inputs other than out_ready are ignored while in ITER or in HOLD
//  without out_ready.
//  Opcode changes after acceptance have no effect (the opcode is latched).
// TESTING (OPD_LENGTH=8, BITS_PER_CYCLE=1)
//  1. Reset: rst_n=0 mid-cycle -> out_valid=0, logic_result=00, illegal_op=0, in_ready=1 immediately.
//  2. opd1=cc, opd2=ff:
//     - AND -> cc, OR -> ff, XOR -> 33, ~opd1 -> 33, ~opd2 -> 00.
//     - out_valid 1 cycle after accept; out_ready held 1 -> 5 results in 5 consecutive cycles.
//  3. opd1=0e, opd2=a0:
//     - AND -> 00, OR -> ae, XOR -> ae, ~opd1 -> f1, ~opd2 -> 5f.
//  4. POPCNT and CLZ:
//     - POPCNT opd1=cc -> 04, out_valid exactly 9 cycles after accept, in_ready=0 for cycles 1..9.
//     - CLZ opd1=0e -> 04; CLZ 00 -> 08; CLZ 80 -> 00; POPCNT ff -> 08.
//  5. Backpressure and illegal op:
//     - Hold out_ready=0 for 3 cycles after XOR result 33 -> result stays 33, in_valid ignored.
//     - Then raise out_ready and in_valid with opcode 0011 together -> next result 00 with illegal_op=1.
//  6. Abort: pull rst_n low 4 cycles into POPCNT -> no out_valid; after release a new AND cc,ff
//     returns cc with 1-cycle latency.

Source files
------------

// File: rtl/logic_unit_seq.sv
// ----------------------------------------------------------------------------
// logic_unit_seq
//
// Sequential, handshaked logic unit placed between the ALU operand stage and
// writeback. The bitwise ops (AND, OR, XOR, ~opd1, ~opd2) finish at the edge
// that accepts them. The bit-scan ops (population count, count leading zeros)
// scan the latched opd1 over OPD_LENGTH/BITS_PER_CYCLE cycles.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       request valid
//   in_ready       unit can accept a request this cycle
//   opd1, opd2     operands (OPD_LENGTH bits)
//   alu_op_select  4-bit operation code
//   out_valid      logic_result / illegal_op are valid
//   out_ready      consumer accepts the result this cycle
//   logic_result   registered result (OPD_LENGTH bits)
//   illegal_op     registered; 1 = unsupported opcode
// ----------------------------------------------------------------------------
module logic_unit_seq #(
    parameter int OPD_LENGTH     = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPD_LENGTH-1:0] opd1,
    input  logic [OPD_LENGTH-1:0] opd2,
    input  logic [3:0]            alu_op_select,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OPD_LENGTH-1:0] logic_result,
    output logic                  illegal_op
);

    localparam int N  = OPD_LENGTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(OPD_LENGTH + 1);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    localparam logic [3:0] OP_AND    = 4'b0111;
    localparam logic [3:0] OP_OR     = 4'b0110;
    localparam logic [3:0] OP_XOR    = 4'b0100;
    localparam logic [3:0] OP_NOT1   = 4'b0000;
    localparam logic [3:0] OP_NOT2   = 4'b0001;
    localparam logic [3:0] OP_POPCNT = 4'b1000;
    localparam logic [3:0] OP_CLZ    = 4'b1001;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              op_q, op_d;
    logic [OPD_LENGTH-1:0]   shift_q, shift_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    seen_q, seen_d;
    logic [SW-1:0]           scan_q, scan_d;
    logic [OPD_LENGTH-1:0]   result_q, result_d;
    logic                    illegal_q, illegal_d;

    logic                    accept;
    logic [CW-1:0]           count_v;
    logic                    seen_v;

    // State register plus all datapath flops; reset also aborts any scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            shift_q   <= '0;
            count_q   <= '0;
            seen_q    <= 1'b0;
            scan_q    <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            shift_q   <= shift_d;
            count_q   <= count_d;
            seen_q    <= seen_d;
            scan_q    <= scan_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and datapath logic.
    // The scan operand is kept in a shift register so the bits under
    // inspection always sit at a fixed position: the low end for POPCNT
    // (LSB-first) and the high end for CLZ (MSB-first). For CLZ the
    // seen flag freezes the count once the first 1 has been passed.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        shift_d   = shift_q;
        count_d   = count_q;
        seen_d    = seen_q;
        scan_d    = scan_q;
        result_d  = result_q;
        illegal_d = illegal_q;

        in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
        out_valid = (state_q == HOLD);
        accept    = in_valid && in_ready;

        count_v = count_q;
        seen_v  = seen_q;
        for (int b = 0; b < BITS_PER_CYCLE; b++) begin
            if (op_q == OP_POPCNT) begin
                count_v = count_v + CW'(shift_q[b]);
            end else begin
                if (!seen_v && !shift_q[OPD_LENGTH-1-b]) begin
                    count_v = count_v + CW'(1);
                end
                if (shift_q[OPD_LENGTH-1-b]) begin
                    seen_v = 1'b1;
                end
            end
        end

        case (state_q)
            ITER: begin
                count_d = count_v;
                seen_d  = seen_v;
                scan_d  = scan_q + SW'(1);
                if (op_q == OP_POPCNT) begin
                    shift_d = shift_q >> BITS_PER_CYCLE;
                end else begin
                    shift_d = shift_q << BITS_PER_CYCLE;
                end
                // The scan length is fixed, so the result is ready after
                // exactly N cycles regardless of the operand value.
                if (scan_q == SW'(N - 1)) begin
                    result_d  = OPD_LENGTH'(count_v);
                    illegal_d = 1'b0;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (out_ready && !in_valid) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // Accept is only possible in IDLE or a retiring HOLD, so it never
        // collides with the ITER updates above.
        if (accept) begin
            op_d    = alu_op_select;
            shift_d = opd1;
            count_d = '0;
            seen_d  = 1'b0;
            scan_d  = '0;
            case (alu_op_select)
                OP_AND: begin
                    result_d  = opd1 & opd2;
                    illegal_d = 1'b0;
                    state_d   = HOLD;
                end
                OP_OR: begin
                    result_d  = opd1 | opd2;
                    illegal_d = 1'b0;
                    state_d   = HOLD;
                end
                OP_XOR: begin
                    result_d  = opd1 ^ opd2;
                    illegal_d = 1'b0;
                    state_d   = HOLD;
                end
                OP_NOT1: begin
                    result_d  = ~opd1;
                    illegal_d = 1'b0;
                    state_d   = HOLD;
                end
                OP_NOT2: begin
                    result_d  = ~opd2;
                    illegal_d = 1'b0;
                    state_d   = HOLD;
                end
                OP_POPCNT, OP_CLZ: begin
                    state_d = ITER;
                end
                default: begin
                    result_d  = '0;
                    illegal_d = 1'b1;
                    state_d   = HOLD;
                end
            endcase
        end
    end

    assign logic_result = result_q;
    assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// ----------------------------------------------------------------------------
// tb_logic_unit_seq
//
// Directed-vector bench for logic_unit_seq (OPD_LENGTH=8, BITS_PER_CYCLE=1).
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_logic_unit_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] opd1;
    logic [7:0] opd2;
    logic [3:0] alu_op_select;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] logic_result;
    logic       illegal_op;

    int checkCount;
    int failCount;

    logic [3:0] bwOps [5];

    logic_unit_seq #(
        .OPD_LENGTH     (8),
        .BITS_PER_CYCLE (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opd1          (opd1),
        .opd2          (opd2),
        .alu_op_select (alu_op_select),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .logic_result  (logic_result),
        .illegal_op    (illegal_op)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op,
                                 input logic [7:0] a, input logic [7:0] b);
        in_valid      = v;
        alu_op_select = op;
        opd1          = a;
        opd2          = b;
    endtask

    // Advance one rising edge and return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Five bitwise ops issued back to back with out_ready held high; each
    // result must appear on the cycle right after its request.
    task automatic runBitwise(input logic [7:0] a, input logic [7:0] b,
                              input logic [39:0] expv);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, bwOps[i], a, b);
            tick();
            checkOutput("bw_valid", out_valid, 1);
            checkOutput("bw_result", logic_result, expv[8*i +: 8]);
            checkOutput("bw_illegal", illegal_op, 0);
        end
        applyStimulus(1'b0, 4'b0111, 8'h00, 8'h00);
        tick();
        checkOutput("bw_drain", out_valid, 0);
    endtask

    // Bit-scan op with out_ready low until the result shows, so in_ready
    // must stay low from the cycle after accept through the first HOLD cycle.
    task automatic runIter(input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] expected);
        int lat;
        out_ready = 1'b0;
        applyStimulus(1'b1, op, a, 8'h5a);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            // Competing request while busy must be ignored.
            applyStimulus(1'b1, 4'b0110, 8'hff, 8'hff);
            checkOutput("iter_in_ready", in_ready, 0);
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        checkOutput("iter_latency", lat, 9);
        checkOutput("iter_result", logic_result, expected);
        checkOutput("iter_illegal", illegal_op, 0);
        applyStimulus(1'b0, 4'b0000, 8'h00, 8'h00);
        out_ready = 1'b1;
        tick();
        checkOutput("iter_retire", out_valid, 0);
    endtask

    initial begin
        bool_init();
        checkCount    = 0;
        failCount     = 0;
        rst_n         = 1'b1;
        out_ready     = 1'b0;
        applyStimulus(1'b0, 4'b0000, 8'h00, 8'h00);

        // 1. Reset asserted mid-cycle takes effect immediately.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_result", logic_result, 8'h00);
        checkOutput("rst_illegal", illegal_op, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 2./3. Bitwise ops, five results in five consecutive cycles.
        $display("[TB] bitwise ops");
        runBitwise(8'hcc, 8'hff, {8'h00, 8'h33, 8'h33, 8'hff, 8'hcc});
        runBitwise(8'h0e, 8'ha0, {8'h5f, 8'hf1, 8'hae, 8'hae, 8'h00});

        // 4. Bit-scan ops.
        $display("[TB] bit-scan ops");
        runIter(4'b1000, 8'hcc, 8'h04);
        runIter(4'b1001, 8'h0e, 8'h04);
        runIter(4'b1001, 8'h00, 8'h08);
        runIter(4'b1001, 8'h80, 8'h00);
        runIter(4'b1000, 8'hff, 8'h08);

        // 5. Backpressure followed by an illegal opcode retiring in the same cycle.
        $display("[TB] backpressure and illegal op");
        out_ready = 1'b1;
        applyStimulus(1'b1, 4'b0100, 8'hcc, 8'hff);
        tick();
        checkOutput("bp_first", logic_result, 8'h33);
        out_ready = 1'b0;
        applyStimulus(1'b1, 4'b0111, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp_valid", out_valid, 1);
            checkOutput("bp_result", logic_result, 8'h33);
            checkOutput("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        applyStimulus(1'b1, 4'b0011, 8'hcc, 8'hff);
        tick();
        checkOutput("ill_valid", out_valid, 1);
        checkOutput("ill_result", logic_result, 8'h00);
        checkOutput("ill_flag", illegal_op, 1);
        applyStimulus(1'b0, 4'b0000, 8'h00, 8'h00);
        tick();
        checkOutput("ill_retire", out_valid, 0);

        // 6. Reset during a scan aborts it without producing a result.
        $display("[TB] abort by reset");
        out_ready = 1'b1;
        applyStimulus(1'b1, 4'b1000, 8'hcc, 8'h00);
        tick();
        applyStimulus(1'b0, 4'b0000, 8'h00, 8'h00);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_rst_valid", out_valid, 0);
        checkOutput("abort_rst_ready", in_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        begin
            logic sawValid;
            sawValid = 1'b0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (out_valid) sawValid = 1'b1;
            end
            checkOutput("abort_no_valid", sawValid, 0);
        end
        applyStimulus(1'b1, 4'b0111, 8'hcc, 8'hff);
        tick();
        checkOutput("abort_and_valid", out_valid, 1);
        checkOutput("abort_and_result", logic_result, 8'hcc);
        checkOutput("abort_and_illegal", illegal_op, 0);
        applyStimulus(1'b0, 4'b0000, 8'h00, 8'h00);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    // Opcode order used by runBitwise: AND, OR, XOR, ~opd1, ~opd2.
    task automatic bool_init();
        bwOps[0] = 4'b0111;
        bwOps[1] = 4'b0110;
        bwOps[2] = 4'b0100;
        bwOps[3] = 4'b0000;
        bwOps[4] = 4'b0001;
    endtask

endmodule
